instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Program-counter and instruction-register stage of the multi-cycle processor; sits directly upstream of the `InstructionMemory` block and directly downstream of it on the read side. It owns the PC, drives `inst_address`, and captures the combinational `read_data` into an instruction register. It presents the instruction to the control FSM through a valid/ack handshake, then advances the PC sequentially or redirects it on a taken branch.

## Interface
Parameters:
- `ADDR_W`, 16, PC and instruction-address width.
- `DATA_W`, 32, instruction width.
- `MEM_DEPTH`, 256, number of instruction words; legal PCs are 0..MEM_DEPTH-1; MEM_DEPTH ≤ 2^ADDR_W.
- `RESET_PC`, 0, PC loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_req`  in  1  control FSM requests the next instruction; honoured only in IDLE.
- `inst_address`  out  ADDR_W  word index to instruction memory; equals PC (registered).
- `mem_read_data`  in  DATA_W  combinational read data from instruction memory.
- `instr`  out  DATA_W  instruction register (IR).
- `opcode`  out  3  IR[31:29], combinational from IR.
- `instr_valid`  out  1  high while IR holds an unconsumed instruction (ISSUE state).
- `instr_ack`  in  1  consumer finished with the instruction; honoured only in ISSUE.
- `branch_taken`  in  1  qualifies `instr_ack`: redirect PC to IR[15:0].
- `halted`  out  1  PC left the legal range; sticky until reset.
- `instr_count`  out  16  instructions retired (acked), saturating at 0xFFFF.

## Operation
- States: IDLE, ISSUE, HALT (encoding in package).
- IDLE: `instr_valid`=0. On `fetch_req`: IR ← `mem_read_data` (address = PC, already stable), go to ISSUE.
- ISSUE: `instr_valid`=1, IR and PC frozen. On `instr_ack`:
  - next = IR[15:0] if `branch_taken`, else PC+1 (computed in ADDR_W+1 bits).
  - If next ≥ MEM_DEPTH: PC unchanged, go to HALT. Otherwise: PC ← next, go to IDLE.
  - `instr_count` increments (saturating) on every accepted ack, including the one causing HALT.
- HALT: `halted`=1, `instr_valid`=0; all inputs ignored until reset. PC does not wrap.
- `fetch_req` outside IDLE, and `instr_ack` outside ISSUE, are ignored. `branch_taken` without `instr_ack` is ignored.
- Reset values: PC=RESET_PC, IR=0, state=IDLE, `instr_valid`=0, `halted`=0, `instr_count`=0. A reset asserted in any state, including mid-handshake, takes effect at that edge, and the pending instruction is discarded.

## Timing
- `fetch_req` sampled high in IDLE at edge N: IR is valid and `instr_valid`=1 from cycle N+1.
- `instr_ack` at edge M: `instr_valid`=0 and the new PC is on `inst_address` from M+1. The earliest next `fetch_req` is accepted at edge M+1, giving a minimum of 2 cycles per instruction.
- `fetch_req` and `instr_ack` may both be held high continuously; the unit then alternates IDLE/ISSUE every cycle.
- No combinational path from any input to any output except `opcode` ← IR.

## Structure
- Shared package `cpu_pkg`: opcode constants OP_LW=3'b000, OP_SW=3'b001, OP_BEQ=3'b010, OP_BLT=3'b011, OP_ADD=3'b100, OP_SUB=3'b101, OP_AND=3'b110, OP_OR=3'b111; fetch state encoding; BR_TARGET_LSB/MSB = 0/15.
- One sub-module: `fetch_pc_next` (combinational). Inputs are PC, IR[15:0] and `branch_taken`; outputs are the next PC and an out-of-range flag. The PC, IR, FSM and counter live in the top.

## Test plan
- Reset then `fetch_req` with memory word 0 = 0x2000_0004 → `inst_address`=0, `instr`=0x2000_0004, `opcode`=3'b001, `instr_valid`=1 one cycle later.
- Ack without branch on PC=2 (0x8000_8000) → PC=3 next cycle, `instr_count` +1, `instr_valid`=0.
- PC=3 holds 0x4108_0005; ack with `branch_taken`=1 → PC=5. Same instruction acked with `branch_taken`=0 → PC=4.
- Branch target 0x0100 with MEM_DEPTH=256 → `halted`=1, PC stays 3; later `fetch_req` is ignored; reset clears to PC=0, `halted`=0.
- Sequential run to PC=255, then ack → HALT with no wrap to 0; `instr_count` equals the number of acks.
- Reset asserted while in ISSUE at the same edge as `instr_ack` with `branch_taken`=1 → PC=RESET_PC, `instr_valid`=0, IR=0, `instr_count`=0; branch not applied.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Opcode constants, fetch state encoding and IR field positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_SW  = 3'b001;
    localparam logic [2:0] OP_BEQ = 3'b010;
    localparam logic [2:0] OP_BLT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_OR  = 3'b111;

    localparam int BR_TARGET_LSB = 0;
    localparam int BR_TARGET_MSB = 15;
    localparam int OPC_LSB       = 29;
    localparam int OPC_MSB       = 31;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t FS_IDLE  = 2'd0;
    localparam fetch_state_t FS_ISSUE = 2'd1;
    localparam fetch_state_t FS_HALT  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Memory-side and control-side signals of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] inst_address;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] instr;
    logic [2:0]        opcode;
    logic              instr_valid;
    logic              instr_ack;
    logic              branch_taken;
    logic              halted;
    logic [15:0]       instr_count;

    modport master (
        input  fetch_req, mem_read_data, instr_ack, branch_taken,
        output inst_address, instr, opcode, instr_valid, halted, instr_count
    );

    modport slave (
        output fetch_req, mem_read_data, instr_ack, branch_taken,
        input  inst_address, instr, opcode, instr_valid, halted, instr_count
    );

endinterface

`default_nettype wire

// File: rtl/fetch_pc_next.sv
// ============================================================================
// Module      : fetch_pc_next
// Description : Next-PC selection (sequential or branch) with range check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_next #(
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 256
) (
    input  wire logic [ADDR_W-1:0] pc,
    input  wire logic [15:0]       br_target,
    input  wire logic              branch_taken,
    output logic      [ADDR_W-1:0] next_pc,
    output logic                   out_of_range
);

    localparam int NW = ADDR_W + 1;

    // One extra bit so PC+1 past the last legal word is seen, not wrapped.
    logic [NW-1:0] w_next;

    assign w_next       = branch_taken ? NW'(br_target) : ({1'b0, pc} + NW'(1));
    assign out_of_range = (w_next >= NW'(MEM_DEPTH));
    assign next_pc      = w_next[ADDR_W-1:0];

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module      : instruction_fetch_unit
// Description : PC / instruction register stage with valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int          DATA_W    = 32,
    parameter int          MEM_DEPTH = 256,
    parameter int unsigned RESET_PC  = 0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    instruction_fetch_unit_if.master bus
);

    localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [15:0]       r_count;

    logic              w_load_ir;
    logic              w_ack_accept;
    logic              w_instr_valid;
    logic              w_halted;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_next_oor;

    fetch_pc_next #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_pc_next (
        .pc           (r_pc),
        .br_target    (r_ir[BR_TARGET_MSB:BR_TARGET_LSB]),
        .branch_taken (bus.branch_taken),
        .next_pc      (w_next_pc),
        .out_of_range (w_next_oor)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FS_IDLE:  if (bus.fetch_req) w_state_next = FS_ISSUE;
            FS_ISSUE: if (bus.instr_ack) w_state_next = w_next_oor ? FS_HALT : FS_IDLE;
            FS_HALT:  w_state_next = FS_HALT;
            default:  w_state_next = FS_IDLE;
        endcase
    end

    always_comb begin
        w_load_ir     = 1'b0;
        w_ack_accept  = 1'b0;
        w_instr_valid = 1'b0;
        w_halted      = 1'b0;
        case (r_state)
            FS_IDLE:  w_load_ir = bus.fetch_req;
            FS_ISSUE: begin
                w_instr_valid = 1'b1;
                w_ack_accept  = bus.instr_ack;
            end
            FS_HALT:  w_halted = 1'b1;
            default:  w_load_ir = 1'b0;
        endcase
    end

    // The ack that triggers HALT still retires, but the PC keeps its last legal value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= C_RESET_PC;
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            if (w_load_ir) begin
                r_ir <= bus.mem_read_data;
            end
            if (w_ack_accept) begin
                if (!w_next_oor) begin
                    r_pc <= w_next_pc;
                end
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end
        end
    end

    assign bus.inst_address = r_pc;
    assign bus.instr        = r_ir;
    assign bus.opcode       = r_ir[OPC_MSB:OPC_LSB];
    assign bus.instr_valid  = w_instr_valid;
    assign bus.halted       = w_halted;
    assign bus.instr_count  = r_count;

endmodule

`default_nettype wire
